and_gate_3bit_bist: RTL and testbench
=====================================

# and_gate_3bit_bist

Self-checking stimulus/response engine for the 3-bit AND gate (`and_gate_3bit`). It drives every one of the 512 input combinations of `a`, `b` and `c` into the gate and samples `y` after a programmable settle time. Each sample is compared against the expected bitwise `a & b & c`, and the block reports a pass/fail verdict, the error count and the first failing vector. It sits beside the gate in hardware, as the synthesizable counterpart of a directed testbench.

## Interface
- `SETTLE`, default 1: cycles between driving a vector and sampling `dut_y`. Legal range 1..15.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sampled only in IDLE and DONE; a high level begins a full sweep.
- `dut_a`  out  3  registered stimulus to the gate's `a`.
- `dut_b`  out  3  registered stimulus to the gate's `b`.
- `dut_c`  out  3  registered stimulus to the gate's `c`.
- `dut_y`  in  3  gate response, treated as combinational from `dut_a/b/c`.
- `busy`  out  1  high from the sweep's first vector through its last CHECK.
- `done`  out  1  level; high in DONE until the next start or reset.
- `pass`  out  1  valid while `done`=1; 1 iff `err_count`==0.
- `err_count`  out  10  number of mismatching vectors (0..512, never wraps).
- `first_err_valid`  out  1  high once any mismatch has been recorded in this sweep.
- `first_err_vec`  out  9  index of the first mismatching vector, encoded {a,b,c}.
- `first_err_y`  out  3  `dut_y` value captured at that first mismatch.

## Operation
- Vector index `vec[8:0]`. Drive mapping: `dut_a`=`vec[8:6]`, `dut_b`=`vec[5:3]`, `dut_c`=`vec[2:0]`. Sweep order is 0 to 511 ascending.
- States:
  - **IDLE**: on `start`, load vec=0, drive vector 0, clear all results, set settle counter to SETTLE, go to SETTLE_WAIT.
  - **SETTLE_WAIT**: decrement the counter each cycle; when counter==1, go to CHECK.
  - **CHECK**: compare `dut_y` with `dut_a & dut_b & dut_c`.
    - On mismatch: `err_count`+1. If `first_err_valid`==0, capture `vec` and `dut_y` and set `first_err_valid`.
    - If vec==511, go to DONE.
    - Otherwise vec+1, drive the new vector, reload the counter, go to SETTLE_WAIT.
  - **DONE**: `done`=1 and `pass` valid. On `start`, behave exactly as IDLE+start (full restart, results cleared).
- `start` is ignored in SETTLE_WAIT and CHECK. It is a level: if still high when DONE is reached, the next sweep begins on the following edge.
- Expected value comes from the registered drive values, not from `vec`. This keeps stimulus and comparison aligned.
- `err_count` is 10 bits, so 512 fits without saturation logic.
- Reset values: state IDLE; `dut_a/b/c`=0; `busy`=0; `done`=0; `pass`=0; `err_count`=0; `first_err_valid`=0; `first_err_vec`=0; `first_err_y`=0.
- Reset mid-sweep: state returns to IDLE on the next edge, all outputs take their reset values and partial results are discarded.

## Timing
- `start` sampled at edge k gives the following at edge k:
  - `dut_a/b/c` = vector 0
  - `busy`=1
  - `done`=0
  - results cleared
- Each vector occupies exactly SETTLE+1 cycles: SETTLE cycles in SETTLE_WAIT, then 1 in CHECK. The `dut_y` sample is taken in the CHECK cycle.
- The next vector appears at the edge that ends CHECK, which is the same edge that updates `err_count` and the first-error registers.
- The last CHECK's edge sets `done`=1 and `busy`=0, at edge k + 512*(SETTLE+1). For SETTLE=1 that is k+1024.
- `pass` and `err_count` are stable for the whole time `done`=1.
- `dut_a/b/c` hold vector 511 in DONE.

## Test plan
- **Healthy gate, SETTLE=1**: wire the real `and_gate_3bit` and pulse `start`.
  - Expect `done` at start+1024 cycles, `pass`=1, `err_count`=0, `first_err_valid`=0.
- **Stuck-at-0 on y[0]**: replace y[0] with 0.
  - Expect `err_count`=64, `first_err_vec`=9'b001001001 (73), `first_err_y`=3'b000, `pass`=0.
- **Stuck-at-1 on y[2]**:
  - Expect `err_count`=448, `first_err_vec`=0, `first_err_y`=3'b100.
- **Settle and hold, SETTLE=3**:
  - Expect `done` at start+2048 cycles.
  - Check `dut_a/b/c` changes only every 4 cycles.
  - Hold `start` high through the sweep and confirm no restart until DONE.
- **Reset mid-sweep**: assert `rst` while vec==200 with a stuck-at-0 fault present.
  - Next cycle, all outputs equal their reset values.
  - A new `start` gives `err_count`=64 again, with no carry-over.
- **Restart from DONE**: after a failing sweep, swap in the healthy gate and pulse `start`.
  - Results clear at the start edge; final `pass`=1, `err_count`=0.

Source files
------------

// File: rtl/and_gate_3bit_bist.sv
// Exhaustive stimulus/response checker for a 3-bit AND gate: sweeps all 512
// {a,b,c} vectors, samples dut_y after SETTLE cycles and reports the verdict.
module and_gate_3bit_bist #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] dut_a,
  output logic [2:0] dut_b,
  output logic [2:0] dut_c,
  input  logic [2:0] dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       first_err_valid,
  output logic [8:0] first_err_vec,
  output logic [2:0] first_err_y
);

  typedef enum logic [1:0] {IDLE, SETTLE_WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state;
  logic [8:0] vec;
  logic [3:0] cnt;
  logic       miss;

  // Expected value is built from the registered drive values, not from vec.
  function automatic logic is_mismatch(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] y);
    return y != (a & b & c);
  endfunction

  assign miss = is_mismatch(dut_a, dut_b, dut_c, dut_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vec             <= '0;
      cnt             <= '0;
      dut_a           <= '0;
      dut_b           <= '0;
      dut_c           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_y     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec                   <= '0;
            {dut_a, dut_b, dut_c} <= '0;
            cnt                   <= SETTLE_LD;
            busy                  <= 1'b1;
            done                  <= 1'b0;
            pass                  <= 1'b0;
            err_count             <= '0;
            first_err_valid       <= 1'b0;
            first_err_vec         <= '0;
            first_err_y           <= '0;
            state                 <= SETTLE_WAIT;
          end
        end
        SETTLE_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (miss) begin
            err_count <= err_count + 10'd1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= vec;
              first_err_y     <= dut_y;
            end
          end
          // Verdict folds in this final sample, since err_count updates on the same edge.
          if (vec == 9'd511) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 10'd0) && !miss;
            state <= DONE;
          end else begin
            vec                   <= vec + 9'd1;
            {dut_a, dut_b, dut_c} <= vec + 9'd1;
            cnt                   <= SETTLE_LD;
            state                 <= SETTLE_WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_3bit_bist.sv
// Bench for and_gate_3bit_bist: a faultable AND-gate model feeds two instances
// (SETTLE=1 and SETTLE=3); sweep verdicts are checked through a scoreboard.
module tb_and_gate_3bit_bist;

  logic       clk;
  logic       rst;
  logic       start;
  logic       start3;
  logic [2:0] sa0;
  logic [2:0] sa1;

  logic [2:0] a1, b1, c1, y1;
  logic       busy1, done1, pass1, fev1;
  logic [9:0] ec1;
  logic [8:0] fvec1;
  logic [2:0] fy1;

  logic [2:0] a3, b3, c3, y3;
  logic       busy3, done3, pass3, fev3;
  logic [9:0] ec3;
  logic [8:0] fvec3;
  logic [2:0] fy3;

  // Gate under test with injectable stuck-at faults (stuck-at-1 dominates).
  assign y1 = ((a1 & b1 & c1) & ~sa0) | sa1;
  assign y3 = ((a3 & b3 & c3) & ~sa0) | sa1;

  and_gate_3bit_bist #(.SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .first_err_valid(fev1), .first_err_vec(fvec1), .first_err_y(fy1)
  );

  and_gate_3bit_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_c(c3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3),
    .first_err_valid(fev3), .first_err_vec(fvec3), .first_err_y(fy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    time t_start;
    int  cnt;
    int  fvalid;
    int  fvec;
    int  fy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate all 512 vectors against the faulty gate.
  function automatic exp_t model(input logic [2:0] s0, input logic [2:0] s1);
    exp_t e;
    logic [2:0] a, b, c, good, bad;
    e.t_start = 0; e.cnt = 0; e.fvalid = 0; e.fvec = 0; e.fy = 0;
    for (int v = 0; v < 512; v++) begin
      a = 3'(v / 64);
      b = 3'((v / 8) % 8);
      c = 3'(v % 8);
      good = a & b & c;
      bad  = (good & ~s0) | s1;
      if (bad != good) begin
        if (e.cnt == 0) begin
          e.fvalid = 1;
          e.fvec   = v;
          e.fy     = int'(bad);
        end
        e.cnt++;
      end
    end
    return e;
  endfunction

  // Monitor: each rising done on the SETTLE=1 instance retires one sweep.
  initial begin
    exp_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done1 && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_latency", int'(($time - 5 - e.t_start) / 10), 1024);
          chk("pass", int'(pass1), (e.cnt == 0) ? 1 : 0);
          chk("err_count", int'(ec1), e.cnt);
          chk("first_err_valid", int'(fev1), e.fvalid);
          chk("first_err_vec", int'(fvec1), e.fvec);
          chk("first_err_y", int'(fy1), e.fy);
          chk("busy_at_done", int'(busy1), 0);
          chk("hold_vec_511", int'({a1, b1, c1}), 511);
        end
        pops++;
      end
      done_prev = done1;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_a"}, int'(a1), 0);
    chk({tag, "_b"}, int'(b1), 0);
    chk({tag, "_c"}, int'(c1), 0);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_errc"}, int'(ec1), 0);
    chk({tag, "_fev"}, int'(fev1), 0);
    chk({tag, "_fvec"}, int'(fvec1), 0);
    chk({tag, "_fy"}, int'(fy1), 0);
  endtask

  task automatic run_sweep(input logic [2:0] s0, input logic [2:0] s1);
    exp_t e;
    int target;
    target = pops + 1;
    @(negedge clk);
    sa0 = s0;
    sa1 = s1;
    e = model(s0, s1);
    start = 1'b1;
    @(posedge clk);
    e.t_start = $time;
    sb_q.push_back(e);
    #1;
    chk("start_busy", int'(busy1), 1);
    chk("start_done", int'(done1), 0);
    chk("start_vec0", int'({a1, b1, c1}), 0);
    chk("start_clr_errc", int'(ec1), 0);
    chk("start_clr_fev", int'(fev1), 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1100 && pops < target; i++) @(negedge clk);
    chk("sweep_finished", (pops >= target) ? 1 : 0, 1);
  endtask

  initial begin
    exp_t e;
    int found;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; sa0 = 3'b000; sa1 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Healthy gate, then the two directed stuck-at faults.
    run_sweep(3'b000, 3'b000);
    chk("healthy_pass", int'(pass1), 1);
    run_sweep(3'b001, 3'b000);
    chk("sa0_errc", int'(ec1), 64);
    chk("sa0_fvec", int'(fvec1), 73);
    chk("sa0_fy", int'(fy1), 0);
    chk("sa0_pass", int'(pass1), 0);
    run_sweep(3'b000, 3'b100);
    chk("sa1_errc", int'(ec1), 448);
    chk("sa1_fvec", int'(fvec1), 0);
    chk("sa1_fy", int'(fy1), 4);

    // Restart straight from a failing DONE with a healthy gate.
    run_sweep(3'b000, 3'b000);
    chk("restart_pass", int'(pass1), 1);
    chk("restart_errc", int'(ec1), 0);

    repeat (3) run_sweep(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Reset in the middle of a faulty sweep.
    @(negedge clk);
    sa0 = 3'b001; sa1 = 3'b000;
    e = model(3'b001, 3'b000);
    start = 1'b1;
    @(posedge clk);
    e.t_start = $time;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      if ({a1, b1, c1} == 9'd200) found = 1;
      else @(negedge clk);
    end
    chk("reached_vec200", found, 1);
    chk("midsweep_errc_nonzero", (ec1 != 0) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrst");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_sweep(3'b001, 3'b000);
    chk("after_rst_errc", int'(ec1), 64);

    // SETTLE=3 instance: start held high throughout, vectors change every 4 cycles.
    @(negedge clk);
    sa0 = 3'b000; sa1 = 3'b000;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    chk("s3_start_busy", int'(busy3), 1);
    chk("s3_start_vec", int'({a3, b3, c3}), 0);
    for (int n = 1; n < 2048; n++) begin
      @(posedge clk);
      #1;
      chk("s3_vec_hold", int'({a3, b3, c3}), n / 4);
      if (done3 || !busy3) chk("s3_early_done", int'(done3), 0);
    end
    @(posedge clk);
    #1;
    chk("s3_done", int'(done3), 1);
    chk("s3_busy_off", int'(busy3), 0);
    chk("s3_pass", int'(pass3), 1);
    chk("s3_errc", int'(ec3), 0);
    chk("s3_vec511", int'({a3, b3, c3}), 511);
    @(posedge clk);
    #1;
    chk("s3_restart_done", int'(done3), 0);
    chk("s3_restart_busy", int'(busy3), 1);
    chk("s3_restart_vec", int'({a3, b3, c3}), 0);
    @(negedge clk);
    start3 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
